// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter (and a future receiver).
package fifo_uart_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} uart_tx_state_e;

  localparam int unsigned MaxDataWidth = 32;

  // Callers zero-extend narrower words; zero padding does not change the XOR.
  function automatic logic even_parity(input logic [MaxDataWidth-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; bit_tick marks the last clk cycle of each serial bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic bit_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serialises it as an 8N1-style UART frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  bit_tick;
  logic                  timer_clr;

  // Held clear until START so the first bit period is full length.
  assign timer_clr = (state_q == IDLE) || (state_q == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (timer_clr),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    frame_done = 1'b0;
    fifo_rd_en = (state_q == IDLE) && enable && !fifo_empty;
    busy       = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (fifo_rd_en) state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifo_data;
        parity_d   = even_parity(MaxDataWidth'(fifo_data));
        bit_idx_d  = '0;
        stop_cnt_d = '0;
        state_d    = START;
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxW'(DATA_WIDTH - 1)) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            stop_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode from the next state so the registered line lines up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two DUT configurations (8N1 and 8E2) fed from one shared word stream.
module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  bit   chk_gap = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] stim_log[$];
  int         rd_ptr[2];
  int         frames[2];
  logic [1:0] rd_en, tx, busy, done;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t: timed out", name, $time);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int unsigned P  = gi;
    localparam int unsigned S  = gi + 1;
    localparam int          NB = 1 + W + P + S;

    logic        fempty_s = 1'b1;
    logic [7:0]  fdata_s = 8'h00;
    logic [15:0] exp_q[$];
    logic [15:0] cur = '1;
    logic [7:0]  pend_v = 8'h00;
    bit          pend = 1'b0;
    bit          prev_rd = 1'b0;
    int          pos = -1;
    int          cyc = 0;
    int          last_start = -1;

    fifo_uart_tx #(
      .DATA_WIDTH  (W),
      .CLKS_PER_BIT(N),
      .PARITY_EN   (P),
      .STOP_BITS   (S)
    ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .fifo_empty(fempty_s),
      .fifo_data (fdata_s),
      .fifo_rd_en(rd_en[gi]),
      .tx        (tx[gi]),
      .busy      (busy[gi]),
      .frame_done(done[gi])
    );

    // Line image of a frame: bit k is the level during serial bit k; unused bits stay high.
    function automatic logic [15:0] frame_bits(input logic [7:0] v);
      logic [15:0] f = '1;
      f[0]   = 1'b0;
      f[8:1] = v;
      if (P != 0) f[9] = ^v;
      return f;
    endfunction

    initial begin : fifo_and_monitor
      forever begin
        @(negedge clk);
        if (!rstn) begin
          exp_q.delete();
          pos        = -1;
          pend       = 1'b0;
          prev_rd    = 1'b0;
          last_start = -1;
        end else begin
          cyc++;
          if (rd_en[gi]) begin
            check("rd_en_when_empty", gi, fempty_s, 0);
            check("rd_en_while_busy", gi, busy[gi], 0);
            check("rd_en_single_pulse", gi, prev_rd, 0);
            if (rd_ptr[gi] < stim_log.size()) begin
              pend_v = stim_log[rd_ptr[gi]];
              rd_ptr[gi]++;
              pend = 1'b1;
              exp_q.push_back(frame_bits(pend_v));
            end
          end
          prev_rd = rd_en[gi];

          if (pos < 0 && tx[gi] === 1'b0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_start", gi, tx[gi], 1);
            end else begin
              cur = exp_q.pop_front();
              pos = 0;
              if (chk_gap && last_start >= 0) check("frame_gap", gi, cyc - last_start, NB * N + 2);
              last_start = chk_gap ? cyc : -1;
            end
          end

          if (pos >= 0) begin
            check("tx_bit", gi, tx[gi], cur[pos / N]);
            check("busy_in_frame", gi, busy[gi], 1);
            check("frame_done", gi, done[gi], pos == NB * N - 1);
            pos++;
            if (pos == NB * N) begin
              pos = -1;
              frames[gi]++;
            end
          end else begin
            check("frame_done_idle", gi, done[gi], 0);
          end
        end

        // Read data appears one cycle after the pop; other cycles carry junk.
        @(posedge clk);
        #1;
        if (pend) begin
          fdata_s = pend_v;
          pend    = 1'b0;
        end else begin
          fdata_s = 8'($urandom);
        end
        fempty_s = (rd_ptr[gi] >= stim_log.size());
      end
    end
  end

  task automatic push(input logic [7:0] v);
    stim_log.push_back(v);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int quiet = 0;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk);
      #3;
      if (busy == 2'b00 && rd_en == 2'b00 && rd_ptr[0] == stim_log.size() &&
          rd_ptr[1] == stim_log.size()) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    timeout(name);
  endtask

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", 2, tx, 2'b11);
    check("reset_busy", 2, busy, 2'b00);
    check("reset_rd_en", 2, rd_en, 2'b00);
    check("reset_done", 2, done, 2'b00);
    rstn = 1'b1;

    // Reset in the middle of the data bits of 8'h3C
    @(posedge clk);
    #2;
    enable = 1'b1;
    push(8'h3C);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = (tx[0] == 1'b0);
    end
    if (!seen) timeout("start_3C");
    repeat (4 * N) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_reset_tx", 2, tx, 2'b11);
    check("async_reset_busy", 2, busy, 2'b00);
    check("async_reset_done", 2, done, 2'b00);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (60) @(posedge clk);
    check("pops_after_reset", 0, rd_ptr[0], 1);
    check("pops_after_reset", 1, rd_ptr[1], 1);

    // Single word, then parity-sensitive pair
    push(8'hA5);
    wait_idle("idle_A5", 200);
    check("frames_A5", 0, frames[0], 1);
    check("frames_A5", 1, frames[1], 1);
    push(8'h07);
    push(8'h03);
    wait_idle("idle_07_03", 300);
    check("frames_07_03", 0, frames[0], 3);
    check("frames_07_03", 1, frames[1], 3);

    // Preloaded burst: frames must run back to back
    chk_gap = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_idle("idle_burst", 400);
    chk_gap = 1'b0;
    check("pops_burst", 0, rd_ptr[0], 7);
    check("pops_burst", 1, rd_ptr[1], 7);
    check("frames_burst", 0, frames[0], 6);

    // Enable dropped during the first of two queued frames
    push(8'h55);
    push(8'hAA);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = (busy == 2'b11);
    end
    if (!seen) timeout("busy_55");
    enable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = (busy == 2'b00);
    end
    if (!seen) timeout("done_55");
    repeat (20) @(posedge clk);
    #2;
    check("pops_disabled", 0, rd_ptr[0], 8);
    check("pops_disabled", 1, rd_ptr[1], 8);
    check("frames_disabled", 0, frames[0], 7);
    check("tx_disabled", 2, tx, 2'b11);
    enable = 1'b1;
    @(negedge clk);
    check("rd_en_on_enable", 2, rd_en, 2'b11);
    @(negedge clk);
    check("load_busy", 2, busy, 2'b11);
    check("load_tx", 2, tx, 2'b11);
    @(negedge clk);
    check("start_after_enable", 2, tx, 2'b00);
    wait_idle("idle_AA", 200);
    check("frames_AA", 1, frames[1], 8);

    // Random words with random gaps and enable toggling
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      push(8'($urandom));
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    @(posedge clk);
    #2;
    enable = 1'b1;
    wait_idle("idle_random", 3000);
    check("frames_total", 0, frames[0], stim_log.size() - 1);
    check("frames_total", 1, frames[1], stim_log.size() - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
